// File: rtl/clock_div_pkg.sv
// Shared definitions for the enable-based clock divider: controller states
// and the default ratio width.
package clock_div_pkg;

  localparam int unsigned DIV_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_period_counter.sv
// Period counter for the clock divider: counts 0..N-1 while active, flags the
// boundary cycle, and predicts whether the next cycle is a boundary.
module div_period_counter
  import clock_div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             active_i,
  input  logic [WIDTH-1:0] ratio_i,
  input  logic [WIDTH-1:0] next_ratio_i,
  output logic             boundary_o,
  output logic             next_boundary_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Ratio is never zero, so N-1 cannot underflow.
  assign boundary_o = (count_q == ratio_i - WIDTH'(1));

  // Outside an active period the counter parks at 0, so the first active
  // cycle after a start always sees c = 0.
  always_comb begin
    count_d = '0;
    if (active_i && !boundary_o) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  assign next_boundary_o = (count_d == next_ratio_i - WIDTH'(1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/clock_div_enable.sv
// Divided-clock enable generator: emits one gateEnable pulse per N-cycle
// period, with a ratio handshake that only changes N on period boundaries.
module clock_div_enable
  import clock_div_pkg::*;
#(
  parameter int unsigned WIDTH       = DIV_WIDTH_DEFAULT,
  parameter int unsigned RESET_RATIO = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             run,
  input  logic [WIDTH-1:0] ratioIn,
  input  logic             ratioValid,
  output logic             ratioReady,
  output logic             gateEnable,
  output logic [WIDTH-1:0] activeRatio,
  output logic             busy
);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] ratio_q, ratio_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             gate_q, gate_d;

  logic             boundary;
  logic             next_boundary;
  logic             accept;
  logic [WIDTH-1:0] ratio_coerced;

  assign accept        = ratioValid && !pend_valid_q;
  assign ratio_coerced = (ratioIn == '0) ? WIDTH'(1) : ratioIn;

  div_period_counter #(
    .WIDTH (WIDTH)
  ) u_counter (
    .clock           (clock),
    .reset           (reset),
    .active_i        (state_q != IDLE),
    .ratio_i         (ratio_q),
    .next_ratio_i    (ratio_d),
    .boundary_o      (boundary),
    .next_boundary_o (next_boundary)
  );

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    ratio_d      = ratio_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;

    unique case (state_q)
      IDLE:     if (run) state_d = RUN;
      RUN:      if (boundary) state_d = run ? RUN : IDLE;
                else if (!run) state_d = STOPPING;
      STOPPING: if (boundary) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    if (state_q == IDLE) begin
      // A ratio accepted in the final boundary cycle is still pending here;
      // with no period to protect it takes effect immediately.
      if (pend_valid_q) begin
        ratio_d      = pend_q;
        pend_valid_d = 1'b0;
      end else if (accept) begin
        ratio_d = ratio_coerced;
      end
    end else begin
      if (pend_valid_q && boundary) begin
        ratio_d      = pend_q;
        pend_valid_d = 1'b0;
      end
      if (accept) begin
        pend_d       = ratio_coerced;
        pend_valid_d = 1'b1;
      end
    end

    gate_d = (state_d != IDLE) && next_boundary;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      ratio_q      <= WIDTH'(RESET_RATIO);
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      gate_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ratio_q      <= ratio_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      gate_q       <= gate_d;
    end
  end

  assign ratioReady  = !pend_valid_q;
  assign gateEnable  = gate_q;
  assign activeRatio = ratio_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: doc/clock_div_enable.md
CLOCK_DIV_ENABLE -- requirements
Module: clock_div_enable

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the division ratio and period counter.
REQ-002 Parameter RESET_RATIO, default 2: active ratio after reset; SHALL be in 1..2^WIDTH-1.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 run  input  1  level request: 1 = generate divided-clock enables, 0 = stop.
REQ-006 ratioIn  input  WIDTH  requested division ratio N.
REQ-007 ratioValid  input  1  ratioIn is valid.
REQ-008 ratioReady  output  1  block can accept a ratio this cycle.
REQ-009 gateEnable  output  1  enable for a downstream clock gater; one high cycle per divided period.
REQ-010 activeRatio  output  WIDTH  ratio currently in effect.
REQ-011 busy  output  1  high in RUN or STOPPING.

Function
REQ-012 States SHALL be IDLE, RUN and STOPPING; period counter c counts 0..N-1 in RUN and STOPPING, where N = activeRatio.
REQ-013 IDLE -> RUN when run=1 is sampled; c=0 in the first RUN cycle.
REQ-014 RUN: c increments each cycle, wrapping N-1 -> 0; the cycle with c=N-1 is the period boundary.
REQ-015 gateEnable SHALL be a flop output, high exactly in boundary cycles of RUN or STOPPING, low otherwise.
REQ-016 First gateEnable pulse SHALL occur in the N-th RUN cycle; N=1 gives gateEnable continuously high in RUN.
REQ-017 RUN -> STOPPING when run=0 is sampled outside a boundary; STOPPING completes the current period including its pulse, then -> IDLE.
REQ-018 run=0 sampled in a boundary cycle: that pulse is emitted and the next state is IDLE; the last output period is never shortened.
REQ-019 run=1 re-sampled during STOPPING SHALL be ignored until IDLE is reached; IDLE with run=1 restarts per REQ-013.
REQ-020 Ratio handshake: transfer when ratioValid and ratioReady in the same cycle; ratioReady = not pendingValid.
REQ-021 In IDLE, an accepted ratio SHALL be written to activeRatio on the next edge, with no pending stage.
REQ-022 In RUN or STOPPING, an accepted ratio SHALL be held as pending and applied at the first boundary strictly after the acceptance cycle; pendingValid clears at that edge.
REQ-023 The ratio in effect at the start of a period SHALL govern that entire period; no period SHALL have an intermediate length.
REQ-024 ratioIn=0 SHALL be coerced to 1 on acceptance.
REQ-025 busy SHALL equal (state != IDLE).

Reset
REQ-026 reset SHALL override all inputs and act on the next rising edge.
REQ-027 Reset values: state=IDLE, c=0, gateEnable=0, pendingValid=0 (ratioReady=1), activeRatio=RESET_RATIO, busy=0.
REQ-028 Reset mid-period SHALL discard the period and any pending ratio without emitting a pulse.

Structure
REQ-029 Shared package `clock_div_pkg`: state enum (IDLE, RUN, STOPPING) and the WIDTH default constant.
REQ-030 One sub-module, `div_period_counter`, SHALL hold c, the boundary compare and wrap; the FSM and handshake SHALL stay in clock_div_enable.

Verification
REQ-031 Reset, run=1, RESET_RATIO=2 -> gateEnable high in RUN cycles 2, 4, 6; busy=1 from RUN cycle 1.
REQ-032 N=3 running; accept ratio 5 at c=1 -> periods 3 then 5; ratioReady=0 until the boundary edge applying 5.
REQ-033 N=4 running; accept ratio 1 in a boundary cycle -> next period still 4, then gateEnable stays high continuously.
REQ-034 N=4; drop run at c=1 -> pulse at c=3, then IDLE with busy=0; raise run at c=2 -> ignored.
REQ-035 In IDLE, accept ratio 0 -> activeRatio=1 on the next cycle and ratioReady stays 1.
REQ-036 N=6, pending ratio 3; assert reset at c=4 -> no pulse, activeRatio=RESET_RATIO, ratioReady=1, state IDLE.
